period_meter: RTL and testbench



---
 rtl/period_meter.sv | 113 +++++++++++
 tb/tb_period_meter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures period and high time of a slow asynchronous square wave
// Counts are in clk50 cycles between consecutive synchronized rising edges of sig_in.
module period_meter #(
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 1000
) (
  input  logic                 clk50,
  input  logic                 reset,
  input  logic                 sig_in,
  input  logic                 start,
  input  logic                 continuous,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 valid,
  output logic                 busy,
  output logic                 timeout
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(TIMEOUT - 1);

  state_t               state, state_n;
  logic                 s1, s2, s3;
  logic                 rise;
  logic [CNT_WIDTH-1:0] cnt, hcnt, wd;
  logic                 wd_expire;
  logic                 do_arm, do_load, do_capture, do_abort;

  assign rise      = s2 & ~s3;
  // Abort on the cycle that would count the TIMEOUT-th rise-free cycle.
  assign wd_expire = (wd == WD_LAST);
  assign busy      = (state != IDLE);

  always_comb begin
    state_n    = state;
    do_arm     = 1'b0;
    do_load    = 1'b0;
    do_capture = 1'b0;
    do_abort   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = ARM;
          do_arm  = 1'b1;
        end
      end
      ARM: begin
        if (rise) begin
          state_n = MEASURE;
          do_load = 1'b1;
        end else if (wd_expire) begin
          state_n  = IDLE;
          do_abort = 1'b1;
        end
      end
      MEASURE: begin
        if (rise) begin
          do_capture = 1'b1;
          if (continuous) do_load = 1'b1;
          else            state_n = IDLE;
        end else if (wd_expire) begin
          state_n  = IDLE;
          do_abort = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      state     <= IDLE;
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      cnt       <= '0;
      hcnt      <= '0;
      wd        <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state <= state_n;
      s1    <= sig_in;
      s2    <= s1;
      s3    <= s2;
      valid <= do_capture;

      if (do_arm)        timeout <= 1'b0;
      else if (do_abort) timeout <= 1'b1;

      if (do_arm)              wd <= '0;
      else if (state != IDLE)  wd <= rise ? '0 : wd + ONE;

      if (do_load) begin
        cnt  <= ONE;
        hcnt <= ONE;
      end else if (state == MEASURE && !rise) begin
        cnt <= cnt + ONE;
        if (s2) hcnt <= hcnt + ONE;
      end

      if (do_capture) begin
        period    <= cnt;
        high_time <= hcnt;
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - scoreboard bench for period_meter
module tb_period_meter;

  localparam int W  = 16;
  localparam int TO = 1200;

  typedef struct packed {
    logic [W-1:0] per;
    logic [W-1:0] hi;
  } exp_t;

  logic         clk50 = 1'b0;
  logic         reset, sig_in, start, continuous;
  logic [W-1:0] period, high_time;
  logic         valid, busy, timeout;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vcount = 0;

  logic gen_on  = 1'b0;
  int   hi_len  = 5;
  int   lo_len  = 5;

  period_meter #(.CNT_WIDTH(W), .TIMEOUT(TO)) dut (
    .clk50(clk50), .reset(reset), .sig_in(sig_in), .start(start),
    .continuous(continuous), .period(period), .high_time(high_time),
    .valid(valid), .busy(busy), .timeout(timeout)
  );

  always #10 clk50 = ~clk50;

  // Source generator: high for hi_len cycles then low for lo_len cycles.
  initial begin
    int ph;
    ph = 0;
    sig_in = 1'b0;
    forever begin
      @(posedge clk50);
      #1;
      if (gen_on) begin
        sig_in = (ph < hi_len);
        ph = (ph + 1 >= hi_len + lo_len) ? 0 : ph + 1;
      end else begin
        sig_in = 1'b0;
        ph = 0;
      end
    end
  end

  // Monitor: every valid pops one expectation.
  always @(negedge clk50) begin
    if (valid === 1'b1) begin
      exp_t e;
      vcount++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid got period=%0d high_time=%0d required no valid", period, high_time);
      end else begin
        e = exp_q.pop_front();
        if (period !== e.per || high_time !== e.hi) begin
          errors++;
          $display("FAIL result got period=%0d high_time=%0d required period=%0d high_time=%0d",
                   period, high_time, e.per, e.hi);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk50);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      tick();
      n++;
    end
    check({name, "_idle_in_time"}, 32'(busy === 1'b0), 32'd1);
  endtask

  task automatic push(input int p, input int h);
    exp_t e;
    e.per = W'(p);
    e.hi  = W'(h);
    exp_q.push_back(e);
  endtask

  initial begin
    int v0, n, waited;
    reset = 1'b1;
    start = 1'b0;
    continuous = 1'b0;
    repeat (4) tick();
    check("reset_period", 32'(period), 0);
    check("reset_high_time", 32'(high_time), 0);
    check("reset_valid", 32'(valid), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_timeout", 32'(timeout), 0);
    reset = 1'b0;
    tick();

    // One-shot, 5 high / 5 low.
    hi_len = 5; lo_len = 5; gen_on = 1'b1;
    repeat (7) tick();
    push(10, 5);
    v0 = vcount;
    pulse_start();
    check("oneshot_busy", 32'(busy), 1);
    wait_idle("oneshot", 100);
    repeat (3) tick();
    check("oneshot_valid_count", 32'(vcount - v0), 1);

    // Continuous, 3 high / 7 low.
    gen_on = 1'b0; hi_len = 3; lo_len = 7;
    repeat (3) tick();
    gen_on = 1'b1;
    continuous = 1'b1;
    repeat (6) push(10, 3);
    pulse_start();
    waited = 0;
    while (waited < 100) begin
      @(negedge clk50);
      if (valid === 1'b1) break;
      waited++;
    end
    check("cont_first_valid_seen", 32'(waited < 100), 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk50);
      if (valid === 1'b1) n++;
    end
    continuous = 1'b0;
    check("cont_pulses_in_40", 32'(n), 4);
    #2;
    wait_idle("cont", 100);
    tick();
    check("cont_queue_drained", 32'(exp_q.size()), 0);

    // Divider loopback: output toggles every 500 clk50 cycles.
    gen_on = 1'b0; hi_len = 500; lo_len = 500;
    repeat (3) tick();
    gen_on = 1'b1;
    push(1000, 500);
    pulse_start();
    wait_idle("loopback", 3000);
    tick();
    check("loopback_queue_drained", 32'(exp_q.size()), 0);

    // Timeout with sig_in stuck low.
    gen_on = 1'b0;
    repeat (5) tick();
    v0 = vcount;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("to_busy_after_start", 32'(busy), 1);
    repeat (TO - 1) tick();
    check("to_not_yet", 32'(timeout), 0);
    check("to_busy_before", 32'(busy), 1);
    tick();
    check("to_flag", 32'(timeout), 1);
    check("to_busy_after", 32'(busy), 0);
    check("to_period_kept", 32'(period), 1000);
    check("to_high_kept", 32'(high_time), 500);
    check("to_no_valid", 32'(vcount - v0), 0);
    repeat (3) tick();
    check("to_sticky", 32'(timeout), 1);
    pulse_start();
    check("to_cleared_by_start", 32'(timeout), 0);

    // Reset while measuring a slow wave; no result may appear.
    hi_len = 50; lo_len = 50; gen_on = 1'b1;
    repeat (80) tick();
    check("rst_busy_before", 32'(busy), 1);
    reset = 1'b1;
    tick();
    check("rst_period", 32'(period), 0);
    check("rst_high_time", 32'(high_time), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_timeout", 32'(timeout), 0);
    reset = 1'b0;

    // Repeated start while busy is ignored.
    gen_on = 1'b0; hi_len = 6; lo_len = 4;
    repeat (3) tick();
    gen_on = 1'b1;
    v0 = vcount;
    push(10, 6);
    pulse_start();
    repeat (7) tick();
    pulse_start();
    check("restart_still_busy", 32'(busy), 1);
    wait_idle("restart", 100);
    repeat (3) tick();
    check("restart_valid_count", 32'(vcount - v0), 1);
    check("final_queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
